// File: rtl/res_collect_8_to_1_pkg.sv
`default_nettype none
// =============================================================================
// res_collect_8_to_1_pkg : shared types and constants for the result collector
// Revision: 1.0
// =============================================================================
package res_collect_8_to_1_pkg;

    localparam int DATA_W          = 16;
    localparam int TIMEOUT_DEFAULT = 15;
    localparam int CNT_W           = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

endpackage : res_collect_8_to_1_pkg
`default_nettype wire

// File: rtl/res_collect_8_to_1_mux.sv
`default_nettype none
// =============================================================================
// mux_8_to_1 : combinational 8:1 selector over the functional-unit result buses
// Revision: 1.0
// =============================================================================
module mux_8_to_1
    import res_collect_8_to_1_pkg::*;
(
    input  logic [7:0][DATA_W-1:0] data_i,
    input  logic [2:0]             sel_i,
    output logic [DATA_W-1:0]      y_o
);

    always_comb begin
        y_o = data_i[sel_i];
    end

endmodule : mux_8_to_1
`default_nettype wire

// File: rtl/res_collect_8_to_1.sv
`default_nettype none
// =============================================================================
// res_collect_8_to_1 : waits for the selected unit's valid, captures its result
//                      and holds it until acknowledged; flags a timeout error.
// Revision: 1.0
// =============================================================================
module res_collect_8_to_1
    import res_collect_8_to_1_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] I0,
    input  logic [DATA_W-1:0] I1,
    input  logic [DATA_W-1:0] I2,
    input  logic [DATA_W-1:0] I3,
    input  logic [DATA_W-1:0] I4,
    input  logic [DATA_W-1:0] I5,
    input  logic [DATA_W-1:0] I6,
    input  logic [DATA_W-1:0] I7,
    input  logic [7:0]        vld,
    input  logic [2:0]        sel,
    input  logic              start,
    input  logic              ack,
    output logic [DATA_W-1:0] Y,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  state_q;
    logic [2:0]              sel_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_W-1:0]       y_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;
    logic [7:0][DATA_W-1:0]  w_bus;
    logic [DATA_W-1:0]       w_mux_y;

    assign w_bus = {I7, I6, I5, I4, I3, I2, I1, I0};

    mux_8_to_1 u_mux (
        .data_i (w_bus),
        .sel_i  (sel_q),
        .y_o    (w_mux_y)
    );

    // Outputs are updated alongside the state so they come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_q   <= sel;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // Capture takes priority over a timeout in the same cycle.
                    if (vld[sel_q]) begin
                        y_q     <= w_mux_y;
                        done_q  <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == C_CNT_LAST) begin
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                end
                HOLD: begin
                    if (ack) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ERR: begin
                    if (ack) begin
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Y    = y_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule : res_collect_8_to_1
`default_nettype wire

// File: tb/tb_res_collect_8_to_1.sv
`default_nettype none
// =============================================================================
// tb_res_collect_8_to_1 : directed self-checking bench for res_collect_8_to_1
// Revision: 1.0
// =============================================================================
module tb_res_collect_8_to_1;

    logic        clk;
    logic        rst;
    logic [15:0] I0, I1, I2, I3, I4, I5, I6, I7;
    logic [7:0]  vld;
    logic [2:0]  sel;
    logic        start;
    logic        ack;
    logic [15:0] Y;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests;
    int n_fail;

    res_collect_8_to_1 #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .I0    (I0),
        .I1    (I1),
        .I2    (I2),
        .I3    (I3),
        .I4    (I4),
        .I5    (I5),
        .I6    (I6),
        .I7    (I7),
        .vld   (vld),
        .sel   (sel),
        .start (start),
        .ack   (ack),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic b, input logic d, input logic e,
                           input logic [15:0] y);
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        check({tag, ".done"}, {31'd0, done}, {31'd0, d});
        check({tag, ".err"},  {31'd0, err},  {31'd0, e});
        check({tag, ".Y"},    {16'd0, Y},    {16'd0, y});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        {I0, I1, I2, I3, I4, I5, I6, I7} = '0;
        vld = 8'h00; sel = 3'd0; start = 1'b0; ack = 1'b0;
        rst = 1'b1;
        #2;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        rst = 1'b0;

        // Reset mid-WAIT abandons the transaction
        sel = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk_out("r_wait", 1'b1, 1'b0, 1'b0, 16'h0000);
        #2 rst = 1'b1;
        #1;
        chk_out("r_async", 1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        rst = 1'b0;
        I3 = 16'hBEEF; vld = 8'h08;
        step();
        step();
        chk_out("r_after", 1'b0, 1'b0, 1'b0, 16'h0000);
        vld = 8'h00;

        // Normal capture from unit 5, valid two cycles after start
        sel = 3'd5; start = 1'b1; I5 = 16'h1234;
        step();
        start = 1'b0;
        step();
        chk_out("n_wait", 1'b1, 1'b0, 1'b0, 16'h0000);
        vld = 8'h20;
        step();
        chk_out("n_hold", 1'b1, 1'b1, 1'b0, 16'h1234);
        vld = 8'h00; ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("n_ack", 1'b0, 1'b0, 1'b0, 16'h1234);

        // Valid from a non-selected unit is ignored
        sel = 3'd2; start = 1'b1;
        step();
        start = 1'b0; vld = 8'h01; I0 = 16'hFFFF;
        step();
        chk_out("w_ign", 1'b1, 1'b0, 1'b0, 16'h1234);
        vld = 8'h04; I2 = 16'h0A0A;
        step();
        chk_out("w_cap", 1'b1, 1'b1, 1'b0, 16'h0A0A);
        vld = 8'h00; ack = 1'b1;
        step();
        ack = 1'b0;

        // Timeout with TIMEOUT=4
        sel = 3'd7; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk_out("t_pre", 1'b1, 1'b0, 1'b0, 16'h0A0A);
        step();
        chk_out("t_err", 1'b1, 1'b0, 1'b1, 16'h0A0A);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("t_ack", 1'b0, 1'b0, 1'b0, 16'h0A0A);

        // Valid on the timeout cycle: capture wins
        sel = 3'd7; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        I7 = 16'h7777; vld = 8'h80;
        step();
        chk_out("s_cap", 1'b1, 1'b1, 1'b0, 16'h7777);
        vld = 8'h02; I1 = 16'h1111; sel = 3'd1; start = 1'b1;
        step();
        start = 1'b0; vld = 8'h00;
        chk_out("s_hold", 1'b1, 1'b1, 1'b0, 16'h7777);
        check("s_selq", {29'd0, dut.sel_q}, 32'd7);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("s_ack", 1'b0, 1'b0, 1'b0, 16'h7777);

        // Back-to-back: sel=0 then sel=6
        sel = 3'd0; start = 1'b1; I0 = 16'h00A0;
        step();
        start = 1'b0; vld = 8'h01;
        step();
        chk_out("b0_hold", 1'b1, 1'b1, 1'b0, 16'h00A0);
        vld = 8'h00; ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("b0_ack", 1'b0, 1'b0, 1'b0, 16'h00A0);
        sel = 3'd6; start = 1'b1; I6 = 16'h6060;
        step();
        start = 1'b0;
        chk_out("b1_wait", 1'b1, 1'b0, 1'b0, 16'h00A0);
        vld = 8'h40;
        step();
        chk_out("b1_hold", 1'b1, 1'b1, 1'b0, 16'h6060);
        vld = 8'h00; ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("b1_ack", 1'b0, 1'b0, 1'b0, 16'h6060);

        // Valid present in the start cycle is not captured there
        sel = 3'd4; start = 1'b1; I4 = 16'h4444; vld = 8'h10;
        step();
        start = 1'b0;
        chk_out("v_start", 1'b1, 1'b0, 1'b0, 16'h6060);
        step();
        chk_out("v_next", 1'b1, 1'b1, 1'b0, 16'h4444);
        vld = 8'h00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_res_collect_8_to_1
`default_nettype wire
